// File: rtl/spine_switch_if.sv
// Spine-side bundle: per-port source flits/valids, destination backpressure,
// delivered flits/strobes and status. The switch uses the slave modport.
interface spine_switch_if #(
  parameter int NPORTS = 4,
  parameter int DWIDTH = 8
);
  logic [NPORTS*DWIDTH-1:0] src_data;
  logic [NPORTS-1:0]        src_valid;
  logic [NPORTS-1:0]        dst_full;
  logic [NPORTS*DWIDTH-1:0] dst_data;
  logic [NPORTS-1:0]        dst_valid;
  logic [NPORTS-1:0]        overflow;
  logic                     busy;

  modport master (
    output src_data, src_valid, dst_full,
    input  dst_data, dst_valid, overflow, busy
  );

  modport slave (
    input  src_data, src_valid, dst_full,
    output dst_data, dst_valid, overflow, busy
  );
endinterface

// File: rtl/spine_switch.sv
// Spine crossbar: per-source holding queues, round-robin single grant per cycle,
// registered one-hot delivery. Define SPINE_STATS_EN to add the delivered_cnt output.
module spine_switch #(
  parameter int NPORTS     = 4,
  parameter int DWIDTH     = 8,
  parameter int HOLD_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rstn,
  spine_switch_if.slave bus
`ifdef SPINE_STATS_EN
  ,
  output logic [15:0]  delivered_cnt
`endif
);
  localparam int PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int AW = (HOLD_DEPTH > 1) ? $clog2(HOLD_DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [DWIDTH-1:0]        mem_q [NPORTS][HOLD_DEPTH];
  logic [DWIDTH-1:0]        mem_d [NPORTS][HOLD_DEPTH];
  logic [AW-1:0]            wr_ptr_q [NPORTS];
  logic [AW-1:0]            wr_ptr_d [NPORTS];
  logic [AW-1:0]            rd_ptr_q [NPORTS];
  logic [AW-1:0]            rd_ptr_d [NPORTS];
  logic [CW-1:0]            cnt_q [NPORTS];
  logic [CW-1:0]            cnt_d [NPORTS];
  logic [NPORTS-1:0]        ovf_q, ovf_d;
  logic [PW-1:0]            last_grant_q, last_grant_d;
  logic [NPORTS-1:0]        dvld_q, dvld_d;
  logic [NPORTS*DWIDTH-1:0] ddata_q, ddata_d;

  logic [DWIDTH-1:0]        head_data [NPORTS];
  logic [PW-1:0]            head_dest [NPORTS];
  logic [NPORTS-1:0]        eligible;
  logic                     gnt_vld;
  logic [PW-1:0]            gnt_idx;
  logic [PW-1:0]            idx;
  logic                     pop, acc;
  logic                     any_queued;

  // Head-of-queue view and round-robin arbitration
  always_comb begin
    eligible = '0;
    for (int p = 0; p < NPORTS; p++) begin
      head_data[p] = mem_q[p][rd_ptr_q[p]];
      head_dest[p] = head_data[p][DWIDTH-1 -: PW];
      eligible[p]  = (cnt_q[p] != '0) && !bus.dst_full[head_dest[p]];
    end
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int i = 1; i <= NPORTS; i++) begin
      idx = last_grant_q + PW'(i);
      if (!gnt_vld && eligible[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  // Queue updates; a full queue still accepts a push when its head pops this cycle
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    pop        = 1'b0;
    acc        = 1'b0;
    any_queued = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin
      pop = gnt_vld && (gnt_idx == PW'(p));
      acc = bus.src_valid[p] && ((cnt_q[p] != CW'(HOLD_DEPTH)) || pop);
      if (acc) begin
        mem_d[p][wr_ptr_q[p]] = bus.src_data[p*DWIDTH +: DWIDTH];
        wr_ptr_d[p]           = wr_ptr_q[p] + AW'(1);
      end else if (bus.src_valid[p]) begin
        ovf_d[p] = 1'b1;
      end
      if (pop) rd_ptr_d[p] = rd_ptr_q[p] + AW'(1);
      if (acc && !pop)      cnt_d[p] = cnt_q[p] + CW'(1);
      else if (!acc && pop) cnt_d[p] = cnt_q[p] - CW'(1);
      if (cnt_q[p] != '0) any_queued = 1'b1;
    end
  end

  // Delivery register: only the granted destination's lane changes
  always_comb begin
    dvld_d       = '0;
    ddata_d      = ddata_q;
    last_grant_d = last_grant_q;
    if (gnt_vld) begin
      dvld_d[head_dest[gnt_idx]]                         = 1'b1;
      ddata_d[int'(head_dest[gnt_idx])*DWIDTH +: DWIDTH] = head_data[gnt_idx];
      last_grant_d                                       = gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int p = 0; p < NPORTS; p++) begin
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
        cnt_q[p]    <= '0;
      end
      ovf_q        <= '0;
      last_grant_q <= PW'(NPORTS - 1);
      dvld_q       <= '0;
      ddata_q      <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      last_grant_q <= last_grant_d;
      dvld_q       <= dvld_d;
      ddata_q      <= ddata_d;
    end
  end

`ifdef SPINE_STATS_EN
  logic [15:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q + {15'd0, |dvld_d};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) stat_q <= '0;
    else       stat_q <= stat_d;
  end

  assign delivered_cnt = stat_q;
`endif

  assign bus.dst_valid = dvld_q;
  assign bus.dst_data  = ddata_q;
  assign bus.overflow  = ovf_q;
  assign bus.busy      = any_queued || (|dvld_q);
endmodule

// File: tb/tb_spine_switch.sv
// Directed bench for spine_switch (NPORTS=4, DWIDTH=8, HOLD_DEPTH=2);
// destination ID is flit bits [7:6].
module tb_spine_switch;
  logic clk = 1'b0;
  logic rstn;
  int   n_cmp = 0;
  int   n_err = 0;

  spine_switch_if #(.NPORTS(4), .DWIDTH(8)) bus ();

`ifdef SPINE_STATS_EN
  logic [15:0] delivered_cnt;
`endif

  spine_switch #(.NPORTS(4), .DWIDTH(8), .HOLD_DEPTH(2)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
`ifdef SPINE_STATS_EN
    ,
    .delivered_cnt (delivered_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rstn          = 1'b0;
    bus.src_data  = '0;
    bus.src_valid = '0;
    bus.dst_full  = '0;
    step();
    step();
    chk("rst_dst_valid", 64'(bus.dst_valid), 64'h0);
    chk("rst_dst_data",  64'(bus.dst_data),  64'h0);
    chk("rst_overflow",  64'(bus.overflow),  64'h0);
    chk("rst_busy",      64'(bus.busy),      64'h0);
    chk("rst_last_grant", 64'(dut.last_grant_q), 64'h3);
`ifdef SPINE_STATS_EN
    chk("rst_stats", 64'(delivered_cnt), 64'h0);
`endif
    rstn = 1'b1;
    step();

    // Contention: ports 0,1,2 all to port 3 in one cycle
    bus.src_valid = 4'b0111;
    bus.src_data  = {8'h00, 8'hC2, 8'hC1, 8'hC0};
    step();
    bus.src_valid = '0;
    chk("cont_busy", 64'(bus.busy), 64'h1);
    step();
    chk("cont_vld0", 64'(bus.dst_valid), 64'h8);
    chk("cont_dat0", 64'(bus.dst_data[31:24]), 64'hC0);
    step();
    chk("cont_vld1", 64'(bus.dst_valid), 64'h8);
    chk("cont_dat1", 64'(bus.dst_data[31:24]), 64'hC1);
    step();
    chk("cont_vld2", 64'(bus.dst_valid), 64'h8);
    chk("cont_dat2", 64'(bus.dst_data[31:24]), 64'hC2);
    chk("cont_last_grant", 64'(dut.last_grant_q), 64'h2);
    step();
    chk("cont_idle_vld",  64'(bus.dst_valid), 64'h0);
    chk("cont_idle_busy", 64'(bus.busy), 64'h0);

    // Single flit 8'hC5 from port 0 to port 3
    bus.src_valid = 4'b0001;
    bus.src_data  = {24'h0, 8'hC5};
    step();
    bus.src_valid = '0;
    chk("single_e1_vld",  64'(bus.dst_valid), 64'h0);
    chk("single_e1_busy", 64'(bus.busy), 64'h1);
    step();
    chk("single_e2_vld",  64'(bus.dst_valid), 64'h8);
    chk("single_e2_dat",  64'(bus.dst_data[31:24]), 64'hC5);
    step();
    chk("single_e3_vld",  64'(bus.dst_valid), 64'h0);
    chk("single_e3_busy", 64'(bus.busy), 64'h0);
    chk("single_hold",    64'(bus.dst_data[31:24]), 64'hC5);

    // Loopback: port 2 to itself
    bus.src_valid = 4'b0100;
    bus.src_data  = {8'h0, 8'h80, 16'h0};
    step();
    bus.src_valid = '0;
    step();
    chk("loop_vld", 64'(bus.dst_valid), 64'h4);
    chk("loop_dat", 64'(bus.dst_data[23:16]), 64'h80);
    step();

    // Backpressure on port 2 for 5 cycles; port 0 keeps flowing
    bus.dst_full  = 4'b0100;
    bus.src_valid = 4'b0011;
    bus.src_data  = {16'h0, 8'h81, 8'h01};
    step();
    bus.src_valid = '0;
    step();
    chk("bp_p0_vld", 64'(bus.dst_valid), 64'h1);
    chk("bp_p0_dat", 64'(bus.dst_data[7:0]), 64'h01);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_blocked_vld", 64'(bus.dst_valid), 64'h0);
      chk("bp_blocked_busy", 64'(bus.busy), 64'h1);
    end
    bus.dst_full = '0;
    step();
    chk("bp_release_vld", 64'(bus.dst_valid), 64'h4);
    chk("bp_release_dat", 64'(bus.dst_data[23:16]), 64'h81);
    step();
    chk("bp_idle_busy", 64'(bus.busy), 64'h0);

    // Overflow: port 3 pushes three flits to a stalled port 1
    bus.dst_full  = 4'b0010;
    bus.src_valid = 4'b1000;
    bus.src_data  = {8'h41, 24'h0};
    step();
    bus.src_data  = {8'h42, 24'h0};
    step();
    chk("ovf_not_yet", 64'(bus.overflow), 64'h0);
    bus.src_data  = {8'h43, 24'h0};
    step();
    bus.src_valid = '0;
    chk("ovf_set", 64'(bus.overflow), 64'h8);
    chk("ovf_blocked_vld", 64'(bus.dst_valid), 64'h0);
    step();
    chk("ovf_sticky", 64'(bus.overflow), 64'h8);
    bus.dst_full = '0;
    step();
    chk("ovf_vld0", 64'(bus.dst_valid), 64'h2);
    chk("ovf_dat0", 64'(bus.dst_data[15:8]), 64'h41);
    step();
    chk("ovf_vld1", 64'(bus.dst_valid), 64'h2);
    chk("ovf_dat1", 64'(bus.dst_data[15:8]), 64'h42);
    step();
    chk("ovf_no_third", 64'(bus.dst_valid), 64'h0);
    chk("ovf_idle_busy", 64'(bus.busy), 64'h0);

    // Full queue accepts a push that coincides with its pop
    bus.dst_full  = 4'b0010;
    bus.src_valid = 4'b0001;
    bus.src_data  = {24'h0, 8'h51};
    step();
    bus.src_data  = {24'h0, 8'h52};
    step();
    bus.dst_full  = '0;
    bus.src_data  = {24'h0, 8'h53};
    step();
    bus.src_valid = '0;
    chk("pp_vld0", 64'(bus.dst_valid), 64'h2);
    chk("pp_dat0", 64'(bus.dst_data[15:8]), 64'h51);
    chk("pp_no_ovf", 64'(bus.overflow), 64'h8);
    step();
    chk("pp_dat1", 64'(bus.dst_data[15:8]), 64'h52);
    step();
    chk("pp_vld2", 64'(bus.dst_valid), 64'h2);
    chk("pp_dat2", 64'(bus.dst_data[15:8]), 64'h53);
    step();
    chk("pp_idle", 64'(bus.dst_valid), 64'h0);

    // Reset mid-flight with two flits stalled toward port 0
    bus.dst_full  = 4'b0001;
    bus.src_valid = 4'b0110;
    bus.src_data  = {8'h0, 8'h03, 8'h02, 8'h0};
    step();
    bus.src_valid = '0;
    chk("mid_busy", 64'(bus.busy), 64'h1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_vld",  64'(bus.dst_valid), 64'h0);
    chk("mid_rst_ovf",  64'(bus.overflow), 64'h0);
    chk("mid_rst_busy", 64'(bus.busy), 64'h0);
`ifdef SPINE_STATS_EN
    chk("mid_rst_stats", 64'(delivered_cnt), 64'h0);
`endif
    step();
    rstn         = 1'b1;
    bus.dst_full = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_vld",  64'(bus.dst_valid), 64'h0);
      chk("post_rst_busy", 64'(bus.busy), 64'h0);
    end
    chk("post_rst_data", 64'(bus.dst_data), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/spine_switch.md
SPINE_SWITCH -- requirements
Module: spine_switch

Interface
REQ-001 Parameter NPORTS, default 4, number of router ports on the spine; power of two, 2..8.
REQ-002 Parameter DWIDTH, default 8, flit width; destination port ID occupies flit bits [DWIDTH-1 -: log2(NPORTS)].
REQ-003 Parameter HOLD_DEPTH, default 2, per-source holding-queue depth in flits; power of two, ≥2.
REQ-004 clk  input  1  single clock, rising edge.
REQ-005 rstn  input  1  asynchronous, active-low reset.
REQ-006 src_data  input  NPORTS*DWIDTH  flit from each port's in_outgoing_data; port p at [p*DWIDTH +: DWIDTH].
REQ-007 src_valid  input  NPORTS  per-port flit-valid pulse (in_outgoing_valid).
REQ-008 dst_full  input  NPORTS  per-port out_fifo_full backpressure.
REQ-009 dst_data  output  NPORTS*DWIDTH  delivered flit to each port's out_incoming_data.
REQ-010 dst_valid  output  NPORTS  one-hot delivery strobe (out_incoming_valid).
REQ-011 overflow  output  NPORTS  sticky per-source drop flag.
REQ-012 busy  output  1  high while any holding queue is non-empty or a delivery is registered.

Function
REQ-013 Every src_valid[p]=1 cycle shall push src_data[p] into queue p; sources have no ready, so the switch never stalls them.
REQ-014 A push into a full queue with no simultaneous pop shall drop the flit and set overflow[p]; a simultaneous pop and push on a full queue shall accept the flit.
REQ-015 A queue head is eligible when its queue is non-empty and dst_full[dest] is low in the same cycle.
REQ-016 Per cycle, exactly one eligible head shall be granted, round-robin: search starts at port (last_grant+1) mod NPORTS; last_grant resets to NPORTS-1.
REQ-017 The granted head shall be popped and registered: on the next rising edge dst_valid[dest]=1 for one cycle and dst_data[dest]=flit; all other dst_valid bits 0.
REQ-018 Minimum latency: src_valid sampled at edge N gives dst_valid high in the cycle after edge N+1 (two-edge latency) with no contention.
REQ-019 dst_data for non-selected ports shall hold its previous value; dst_data is not zeroed between deliveries.
REQ-020 A flit whose destination equals its source port shall be delivered normally (loopback).
REQ-021 No eligible head shall leave last_grant unchanged and drive dst_valid=0.
REQ-022 A head blocked by dst_full shall block only its own queue; other queues continue to be served (no head-of-line coupling across sources).
REQ-023 Queue pointers shall wrap modulo HOLD_DEPTH; flit order within one source is preserved end-to-end.

Reset
REQ-024 While rstn=0: all queues empty, last_grant=NPORTS-1, dst_valid=0, dst_data=0, overflow=0, busy=0, stats counter (if built)=0.
REQ-025 Reset asserted mid-operation shall discard all queued and in-flight flits; no dst_valid pulse shall follow reset release until a new push.

Configuration
REQ-026 Macro SPINE_STATS_EN defined: extra output delivered_cnt [15:0] counts dst_valid pulses, wraps at 16'hFFFF→0, reset to 0.
REQ-027 SPINE_STATS_EN undefined: delivered_cnt port and counter are absent; all other behaviour identical.

Verification
REQ-028 Single flit: src_valid[0]=1, src_data[0]=8'hC5 (dest 3) at edge 1 -> dst_valid=4'b1000, dst_data[3]=8'hC5 after edge 2, busy low after edge 3.
REQ-029 Contention: ports 0,1,2 each send one flit to port 3 in the same cycle -> deliveries in order 0,1,2 on three consecutive cycles, last_grant=2.
REQ-030 Backpressure: dst_full[2]=1 held 5 cycles, port 1 sends 8'h81 (dest 2) and port 0 sends 8'h01 (dest 0) -> 8'h01 delivered immediately; 8'h81 delivered the cycle after dst_full[2] drops.
REQ-031 Overflow: dst_full[1]=1, port 3 sends 3 flits to port 1 on consecutive cycles with HOLD_DEPTH=2 -> third dropped, overflow[3]=1 sticky, first two delivered in order after release.
REQ-032 Reset mid-flight: two flits queued, rstn=0 for one cycle -> dst_valid stays 0, overflow=0, busy=0; with SPINE_STATS_EN, delivered_cnt=0.
